// File: rtl/vga_state_display.sv
// VGA timing generator with a game-state screen selector.
// One clock domain: a divider produces a pixel enable (pe) that gates every
// register update. The counters drive ADDRH/ADDRV directly; the frame source
// answers on CIN within one pixel, and COUT/HS/VS are registered one pixel
// later so that all three line up on the DAC side.
// MASTER_STATE is sampled only at the first pixel of a frame, so a frame is
// never split between two screens. Won/lost fills can blink with a period
// measured in frames.
module vga_state_display #(
    parameter int CLK_DIV      = 2,
    parameter int H_ACTIVE     = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_ACTIVE     = 480,
    parameter int V_FP         = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 33,
    parameter int COLOUR_W     = 8,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic [1:0]          MASTER_STATE,
    input  logic                BLINK_EN,
    input  logic [COLOUR_W-1:0] WON_COLOUR,
    input  logic [COLOUR_W-1:0] LOST_COLOUR,
    input  logic [COLOUR_W-1:0] CIN,
    output logic [9:0]          ADDRH,
    output logic [8:0]          ADDRV,
    output logic [COLOUR_W-1:0] COUT,
    output logic                HS,
    output logic                VS,
    output logic                FRAME_START
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] H_SYNC_S = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SYNC_E = 10'(H_ACTIVE + H_FP + H_SYNC);

    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] V_SYNC_S = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SYNC_E = 10'(V_ACTIVE + V_FP + V_SYNC);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);

    logic [DIV_W-1:0]    div_cnt;
    logic                pe;
    logic [9:0]          hcnt;
    logic [9:0]          vcnt;
    logic [9:0]          h_next;
    logic [9:0]          v_next;
    logic                h_wrap;
    logic                visible;
    logic                next_visible;
    logic                hs_raw;
    logic                vs_raw;
    logic                frame_pe;
    logic [1:0]          state_q;
    logic [1:0]          state_eff;
    logic [FC_W-1:0]     frame_cnt;
    logic [FC_W-1:0]     frame_cnt_nx;
    logic                blink_phase;
    logic                phase_nx;
    logic [COLOUR_W-1:0] pixel_colour;

    // Pixel enable on the last cycle of each divider period; CLK_DIV=1 makes it constant.
    assign pe = (div_cnt == DIV_LAST);

    // Divider counting CLK cycles within a pixel period.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            div_cnt <= '0;
        end else if (pe) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Next counter values, visibility and raw (undelayed) sync levels.
    always_comb begin
        h_wrap       = (hcnt == H_LAST);
        h_next       = h_wrap ? 10'd0 : hcnt + 10'd1;
        v_next       = vcnt;
        if (h_wrap) begin
            v_next = (vcnt == V_LAST) ? 10'd0 : vcnt + 10'd1;
        end
        visible      = (hcnt < H_VIS) && (vcnt < V_VIS);
        next_visible = (h_next < H_VIS) && (v_next < V_VIS);
        hs_raw       = !((hcnt >= H_SYNC_S) && (hcnt < H_SYNC_E));
        vs_raw       = !((vcnt >= V_SYNC_S) && (vcnt < V_SYNC_E));
        frame_pe     = pe && (hcnt == 10'd0) && (vcnt == 10'd0);
    end

    // Raster counters; the address outputs follow the counters in the same edge.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            hcnt  <= '0;
            vcnt  <= '0;
            ADDRH <= '0;
            ADDRV <= '0;
        end else if (pe) begin
            hcnt  <= h_next;
            vcnt  <= v_next;
            ADDRH <= next_visible ? h_next : 10'd0;
            ADDRV <= next_visible ? v_next[8:0] : 9'd0;
        end
    end

    // Frame-boundary view of state and blink: pixel (0,0) already uses the new frame's values.
    always_comb begin
        state_eff    = state_q;
        frame_cnt_nx = frame_cnt;
        phase_nx     = blink_phase;
        if (frame_pe) begin
            state_eff = MASTER_STATE;
            if (MASTER_STATE != state_q) begin
                frame_cnt_nx = '0;
                phase_nx     = 1'b0;
            end else if (frame_cnt == FC_LAST) begin
                frame_cnt_nx = '0;
                phase_nx     = ~blink_phase;
            end else begin
                frame_cnt_nx = frame_cnt + 1'b1;
            end
        end
    end

    // Screen state and blink bookkeeping, updated only at the start of a frame.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= '0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_pe) begin
            state_q     <= MASTER_STATE;
            frame_cnt   <= frame_cnt_nx;
            blink_phase <= phase_nx;
        end
    end

    // Colour of the pixel whose address is currently presented to the frame source.
    always_comb begin
        pixel_colour = '0;
        if (visible) begin
            case (state_eff)
                2'd1:    pixel_colour = CIN;
                2'd2:    pixel_colour = (BLINK_EN && phase_nx) ? '0 : WON_COLOUR;
                2'd3:    pixel_colour = (BLINK_EN && phase_nx) ? '0 : LOST_COLOUR;
                default: pixel_colour = '0;
            endcase
        end
    end

    // Output stage: colour and syncs leave together, one pixel after the address.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            COUT        <= '0;
            HS          <= 1'b1;
            VS          <= 1'b1;
            FRAME_START <= 1'b0;
        end else begin
            FRAME_START <= frame_pe;
            if (pe) begin
                COUT <= pixel_colour;
                HS   <= hs_raw;
                VS   <= vs_raw;
            end
        end
    end

endmodule

// File: tb/tb_vga_state_display.sv
// Directed bench for vga_state_display.
// dut_a: default 640x480 timing, CLK_DIV=2, first lines only.
// dut_b: tiny 8x4 raster, CLK_DIV=1, BLINK_FRAMES=2, whole frames.
module tb_vga_state_display;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // dut_a signals
    logic       rst_a;
    logic [1:0] ms_a;
    logic       blink_a;
    logic [7:0] won_a;
    logic [7:0] lost_a;
    logic [7:0] cin_a;
    logic [9:0] addr_h_a;
    logic [8:0] addr_v_a;
    logic [7:0] cout_a;
    logic       hs_a;
    logic       vs_a;
    logic       fs_a;

    // dut_b signals
    logic       rst_b;
    logic [1:0] ms_b;
    logic       blink_b;
    logic [7:0] won_b;
    logic [7:0] lost_b;
    logic [7:0] cin_b;
    logic [9:0] addr_h_b;
    logic [8:0] addr_v_b;
    logic [7:0] cout_b;
    logic       hs_b;
    logic       vs_b;
    logic       fs_b;

    // Frame sources: answer each address with a colour derived from it.
    assign cin_a = addr_h_a[7:0];
    assign cin_b = {addr_v_b[3:0], addr_h_b[3:0]};

    vga_state_display dut_a (
        .CLK          (clk),
        .RESET_N      (rst_a),
        .MASTER_STATE (ms_a),
        .BLINK_EN     (blink_a),
        .WON_COLOUR   (won_a),
        .LOST_COLOUR  (lost_a),
        .CIN          (cin_a),
        .ADDRH        (addr_h_a),
        .ADDRV        (addr_v_a),
        .COUT         (cout_a),
        .HS           (hs_a),
        .VS           (vs_a),
        .FRAME_START  (fs_a)
    );

    vga_state_display #(
        .CLK_DIV      (1),
        .H_ACTIVE     (8),
        .H_FP         (2),
        .H_SYNC       (2),
        .H_BP         (2),
        .V_ACTIVE     (4),
        .V_FP         (1),
        .V_SYNC       (1),
        .V_BP         (1),
        .COLOUR_W     (8),
        .BLINK_FRAMES (2)
    ) dut_b (
        .CLK          (clk),
        .RESET_N      (rst_b),
        .MASTER_STATE (ms_b),
        .BLINK_EN     (blink_b),
        .WON_COLOUR   (won_b),
        .LOST_COLOUR  (lost_b),
        .CIN          (cin_b),
        .ADDRH        (addr_h_b),
        .ADDRV        (addr_v_b),
        .COUT         (cout_b),
        .HS           (hs_b),
        .VS           (vs_b),
        .FRAME_START  (fs_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Count negedges until FRAME_START is seen, bounded.
    task automatic wait_fs(input bit sel_b, input int exp_n);
        int n;
        n = 0;
        while (((sel_b ? fs_b : fs_a) !== 1'b1) && (n < 20)) begin
            @(negedge clk);
            n++;
        end
        chk(sel_b ? "b_fs_latency" : "a_fs_latency", n, exp_n);
    endtask

    // Check dut_a cycle by cycle from a FRAME_START negedge (c=0) for ncyc cycles.
    task automatic line_check_a(input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            int n, h, v, m, mh, mv;
            n  = c / 2;
            h  = n % 800;
            v  = n / 800;
            m  = n + 1;
            mh = m % 800;
            mv = m / 800;
            chk("a_hs", hs_a, ((h >= 656) && (h < 752)) ? 0 : 1);
            chk("a_vs", vs_a, 1);
            chk("a_fs", fs_a, (c == 0) ? 1 : 0);
            chk("a_cout", cout_a, ((h < 640) && (v < 480)) ? (h % 256) : 0);
            chk("a_addrh", addr_h_a, (mh < 640) ? mh : 0);
            chk("a_addrv", addr_v_a, (mh < 640) ? mv : 0);
            if (c < ncyc - 1) @(negedge clk);
        end
    endtask

    // Check one dut_b frame from its FRAME_START negedge. Pixels up to
    // switch_k use code_a, later ones code_b (-1 = frame-source pattern).
    // The action is applied right after checking pixel switch_k.
    task automatic run_frame_b(input int code_a, input int code_b,
                               input int switch_k, input int action);
        for (int k = 0; k < 98; k++) begin
            int h, v, m, mh, mv, code, col;
            h    = k % 14;
            v    = k / 14;
            m    = (k + 1) % 98;
            mh   = m % 14;
            mv   = m / 14;
            code = (k <= switch_k) ? code_a : code_b;
            col  = 0;
            if ((h < 8) && (v < 4)) col = (code < 0) ? (v * 16 + h) : code;
            chk("b_hs", hs_b, ((h >= 10) && (h < 12)) ? 0 : 1);
            chk("b_vs", vs_b, (v == 5) ? 0 : 1);
            chk("b_fs", fs_b, (k == 0) ? 1 : 0);
            chk("b_cout", cout_b, col);
            chk("b_addrh", addr_h_b, ((mh < 8) && (mv < 4)) ? mh : 0);
            chk("b_addrv", addr_v_b, ((mh < 8) && (mv < 4)) ? mv : 0);
            if (k == switch_k) begin
                case (action)
                    1: ms_b = 2'd2;
                    2: blink_b = 1'b0;
                    3: ms_b = 2'd3;
                    4: blink_b = 1'b1;
                    default: ;
                endcase
            end
            @(negedge clk);
        end
    endtask

    initial begin
        // Clock/reset block
        rst_a = 1'b0; ms_a = 2'd1; blink_a = 1'b0; won_a = 8'h55; lost_a = 8'haa;
        rst_b = 1'b0; ms_b = 2'd1; blink_b = 1'b1; won_b = 8'h20; lost_b = 8'h07;
        repeat (3) @(negedge clk);

        // Reset state of both instances
        chk("a_rst_hs", hs_a, 1);
        chk("a_rst_vs", vs_a, 1);
        chk("a_rst_cout", cout_a, 0);
        chk("a_rst_addrh", addr_h_a, 0);
        chk("a_rst_addrv", addr_v_a, 0);
        chk("a_rst_fs", fs_a, 0);
        chk("b_rst_hs", hs_b, 1);
        chk("b_rst_vs", vs_b, 1);
        chk("b_rst_cout", cout_b, 0);
        chk("b_rst_fs", fs_b, 0);

        // dut_a: first frame start two CLKs after release, then run into the sync pulse
        rst_a = 1'b1;
        wait_fs(1'b0, 2);
        line_check_a(1401);

        // dut_a: reset at H=700 (HS low) acts immediately
        rst_a = 1'b0;
        #1;
        chk("a_mid_rst_hs", hs_a, 1);
        chk("a_mid_rst_cout", cout_a, 0);
        chk("a_mid_rst_addrh", addr_h_a, 0);
        chk("a_mid_rst_addrv", addr_v_a, 0);
        chk("a_mid_rst_fs", fs_a, 0);
        repeat (3) @(negedge clk);
        chk("a_held_rst_hs", hs_a, 1);

        // dut_a: restart, full first line plus the start of the second
        rst_a = 1'b1;
        wait_fs(1'b0, 2);
        line_check_a(1700);

        // dut_b: small raster, CLK_DIV=1
        @(negedge clk);
        rst_b = 1'b1;
        wait_fs(1'b1, 1);
        run_frame_b(-1, -1, 40, 1);     // playing; switch to won mid-frame
        run_frame_b(32, 32, 50, 3);     // won fill; request lost for next frame
        run_frame_b(7, 7, 200, 0);      // lost, blink frame 0
        run_frame_b(7, 7, 200, 0);      // lost, blink frame 1
        run_frame_b(0, 7, 20, 2);       // blank phase; blink disabled mid-frame
        run_frame_b(7, 7, 97, 4);       // blink off; re-enable at last pixel
        run_frame_b(7, 7, 200, 0);      // lit phase again
        run_frame_b(7, 7, 200, 0);
        run_frame_b(0, 0, 30, 1);       // blank phase; request won
        run_frame_b(32, 32, 200, 0);    // new state starts lit

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vga_state_display.md
VGA_STATE_DISPLAY -- requirements
Module: vga_state_display

Interface
REQ-001 The module SHALL expose parameters, one per line, as name, default, meaning:
 CLK_DIV, 2, CLK cycles per pixel (>=1)
 H_ACTIVE, 640, visible pixels per line
 H_FP, 16, horizontal front porch (pixels)
 H_SYNC, 96, horizontal sync width (pixels)
 H_BP, 48, horizontal back porch (pixels)
 V_ACTIVE, 480, visible lines per frame
 V_FP, 10, vertical front porch (lines)
 V_SYNC, 2, vertical sync width (lines)
 V_BP, 33, vertical back porch (lines)
 COLOUR_W, 8, colour bus width
 BLINK_FRAMES, 30, frames per blink half-period (>=1)
REQ-002 The module SHALL have these ports (name direction width meaning):
 CLK  in  1  system clock, single clock domain, rising edge
 RESET_N  in  1  asynchronous active-low reset
 MASTER_STATE  in  2  0 idle, 1 playing, 2 won, 3 lost
 BLINK_EN  in  1  enable blinking of won/lost screens
 WON_COLOUR  in  COLOUR_W  fill colour for won
 LOST_COLOUR  in  COLOUR_W  fill colour for lost
 CIN  in  COLOUR_W  pixel colour from frame source for the current ADDRH/ADDRV
 ADDRH  out  10  visible pixel column
 ADDRV  out  9  visible pixel row
 COUT  out  COLOUR_W  colour to DAC
 HS  out  1  horizontal sync, active low
 VS  out  1  vertical sync, active low
 FRAME_START  out  1  one-CLK pulse at the start of each frame

Function
REQ-003 A divider SHALL assert an internal pixel enable (PE) once every CLK_DIV CLK cycles; with CLK_DIV=1, PE SHALL be asserted on every cycle.
REQ-004 HCNT SHALL count 0..H_TOTAL-1 (H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP) on PE, then wrap to 0.
REQ-005 VCNT SHALL advance on PE when HCNT wraps, count 0..V_TOTAL-1, then wrap to 0.
REQ-006 ADDRH SHALL equal HCNT, and ADDRV SHALL equal VCNT, while both are in the visible range; otherwise both SHALL be 0.
REQ-007 Raw HS SHALL be low for H_ACTIVE+H_FP <= HCNT < H_ACTIVE+H_FP+H_SYNC; raw VS SHALL be low for V_ACTIVE+V_FP <= VCNT < V_ACTIVE+V_FP+V_SYNC.
REQ-008 CIN SHALL be sampled one pixel period after ADDRH/ADDRV. HS, VS and the blank flag SHALL be delayed by one pixel period so that COUT, HS and VS are aligned with each other.
REQ-009 COUT SHALL be 0 while the delayed blank flag is set.
REQ-010 MASTER_STATE SHALL be latched into STATE_Q only on the PE where HCNT=0 and VCNT=0, so a state change never tears a frame.
REQ-011 FRAME_START SHALL pulse high for exactly one CLK on that same PE.
REQ-012 In the visible region, COUT SHALL be selected from STATE_Q:
 0 -> 0
 1 -> CIN
 2 -> WON_COLOUR
 3 -> LOST_COLOUR
REQ-013 The frame counter SHALL count frames 0..BLINK_FRAMES-1, and the blink phase SHALL toggle when the counter wraps.
REQ-014 In STATE_Q 2 or 3 with BLINK_EN=1 and blink phase=1, COUT SHALL be 0.
REQ-015 When STATE_Q changes, the blink phase and frame counter SHALL clear to 0, so every new state shows its fill colour first.
REQ-016 A BLINK_EN change SHALL take effect at the next pixel; it is not frame-latched.
REQ-017 All outputs SHALL be registered, and all logic SHALL be clocked by CLK only, using PE as a clock enable; no derived clocks are permitted.

Reset
REQ-018 While RESET_N=0, the block SHALL force: divider, HCNT, VCNT, frame counter and blink phase to 0; STATE_Q to 0; HS=1, VS=1; COUT=0; ADDRH=0, ADDRV=0; FRAME_START=0.
REQ-019 After RESET_N rises, the first PE SHALL start a frame, with HCNT=0, VCNT=0 and a FRAME_START pulse.
REQ-020 Reset asserted mid-line or mid-frame SHALL take effect immediately, with no partial sync pulse held.

Verification
REQ-021 Default parameters, CLK_DIV=2, after reset: HS falls 656 pixels (1312 CLK) after FRAME_START, stays low for 96 pixels, and the line period is 800 pixels; VS is low during lines 490-491, and the frame period is 525 lines.
REQ-022 MASTER_STATE=1, CIN = ADDRH[7:0]: COUT at visible pixel n equals n mod 256, aligned with HS; COUT=0 across H 640-799.
REQ-023 MASTER_STATE changes 1->2 mid-frame, WON_COLOUR=8'h20: the current frame continues to show CIN, and the next frame is solid 8'h20 after FRAME_START.
REQ-024 MASTER_STATE=3, LOST_COLOUR=8'h07, BLINK_EN=1, BLINK_FRAMES=2: frames 0-1 are 8'h07, frames 2-3 are 0, frames 4-5 are 8'h07; with BLINK_EN=0 every frame is 8'h07.
REQ-025 RESET_N pulsed low at H=700 during the sync pulse: HS=1, COUT=0 and counters 0 immediately; the first FRAME_START follows the first PE after release.
REQ-026 CLK_DIV=1 and small timing (H 8/2/2/2, V 4/1/1/1): the line period is 14 CLK, the frame period is 98 CLK, and the REQ-007 sync positions are exact.
